xrv1_rf_scb: RTL and testbench

XRV1_RF_SCB -- requirements
Module: xrv1_rf_scb

---
 rtl/xrv1_rf_scb.sv | 124 ++++++++++++
 tb/tb_xrv1_rf_scb.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xrv1_rf_scb.sv
// rtl/xrv1_rf_scb.sv - register file with init sweep and busy scoreboard
// Optional macro XRV1_RF_BYPASS_EN: same-cycle write-to-read data bypass.
module xrv1_rf_scb #(
  parameter int DATA_WIDTH_P    = 32,
  parameter int RF_ADDR_WIDTH_P = 5,
  parameter int NUM_RD_P        = 2,
  parameter int NUM_WR_P        = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  output logic                                 ready_o,
  input  logic [NUM_RD_P*RF_ADDR_WIDTH_P-1:0]  rs_addr_i,
  output logic [NUM_RD_P*DATA_WIDTH_P-1:0]     rs_data_o,
  output logic [NUM_RD_P-1:0]                  rs_busy_o,
  input  logic [NUM_WR_P-1:0]                  rd_w_en_i,
  input  logic [NUM_WR_P*RF_ADDR_WIDTH_P-1:0]  rd_addr_i,
  input  logic [NUM_WR_P*DATA_WIDTH_P-1:0]     rd_data_i,
  input  logic                                 rsv_en_i,
  input  logic [RF_ADDR_WIDTH_P-1:0]           rsv_addr_i
);

  localparam int RF_SIZE = 1 << RF_ADDR_WIDTH_P;
  localparam logic [RF_ADDR_WIDTH_P-1:0] LAST_ENTRY = RF_ADDR_WIDTH_P'(RF_SIZE - 1);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e                     state_q;
  state_e                     state_d;
  logic [RF_ADDR_WIDTH_P-1:0] cnt_q;
  logic [RF_SIZE-1:0]         busy_q;
  logic [DATA_WIDTH_P-1:0]    mem_q [RF_SIZE];

  logic [RF_ADDR_WIDTH_P-1:0] rd_ra;
  logic [DATA_WIDTH_P-1:0]    rd_val;

  // State register; reset always restarts the clearing sweep
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: leave INIT once the last entry has been cleared
  always_comb begin
    state_d = state_q;
    if (state_q == ST_INIT && cnt_q == LAST_ENTRY) begin
      state_d = ST_READY;
    end
  end

  // Output decode
  always_comb begin
    ready_o = (state_q == ST_READY);
  end

  // Sweep counter, advances one entry per INIT cycle and wraps back to 0
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (state_q == ST_INIT) begin
      cnt_q <= cnt_q + RF_ADDR_WIDTH_P'(1);
    end
  end

  // Storage: cleared by the sweep, then written with higher ports overriding lower
  always_ff @(posedge clk_i) begin
    if (state_q == ST_INIT) begin
      mem_q[cnt_q] <= '0;
    end else begin
      for (int k = 0; k < NUM_WR_P; k++) begin
        if (rd_w_en_i[k] && rd_addr_i[k*RF_ADDR_WIDTH_P +: RF_ADDR_WIDTH_P] != '0) begin
          mem_q[rd_addr_i[k*RF_ADDR_WIDTH_P +: RF_ADDR_WIDTH_P]] <=
            rd_data_i[k*DATA_WIDTH_P +: DATA_WIDTH_P];
        end
      end
    end
  end

  // Scoreboard: writes retire a producer, a reserve installs one and takes precedence
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else if (state_q == ST_READY) begin
      for (int k = 0; k < NUM_WR_P; k++) begin
        if (rd_w_en_i[k]) begin
          busy_q[rd_addr_i[k*RF_ADDR_WIDTH_P +: RF_ADDR_WIDTH_P]] <= 1'b0;
        end
      end
      if (rsv_en_i && rsv_addr_i != '0) begin
        busy_q[rsv_addr_i] <= 1'b1;
      end
    end
  end

  // Combinational read ports; address 0 and the INIT phase read as zero and not busy
  always_comb begin
    rs_data_o = '0;
    rs_busy_o = '0;
    rd_ra     = '0;
    rd_val    = '0;
    for (int k = 0; k < NUM_RD_P; k++) begin
      rd_ra  = rs_addr_i[k*RF_ADDR_WIDTH_P +: RF_ADDR_WIDTH_P];
      rd_val = '0;
      if (state_q == ST_READY && rd_ra != '0) begin
        rd_val = mem_q[rd_ra];
`ifdef XRV1_RF_BYPASS_EN
        for (int j = 0; j < NUM_WR_P; j++) begin
          if (rd_w_en_i[j] && rd_addr_i[j*RF_ADDR_WIDTH_P +: RF_ADDR_WIDTH_P] == rd_ra) begin
            rd_val = rd_data_i[j*DATA_WIDTH_P +: DATA_WIDTH_P];
          end
        end
`endif
        rs_busy_o[k] = busy_q[rd_ra];
      end
      rs_data_o[k*DATA_WIDTH_P +: DATA_WIDTH_P] = rd_val;
    end
  end

endmodule

// File: tb/tb_xrv1_rf_scb.sv
// tb/tb_xrv1_rf_scb.sv - self-checking bench for xrv1_rf_scb (default parameters)
module tb_xrv1_rf_scb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ready;
  logic [9:0]  rs_addr = '0;
  logic [63:0] rs_data;
  logic [1:0]  rs_busy;
  logic [1:0]  rd_w_en = '0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data = '0;
  logic        rsv_en = 1'b0;
  logic [4:0]  rsv_addr = '0;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference model state
  logic [31:0] m_mem [32];
  bit          m_busy [32];
  int          m_sweep = 0;

  always #5 clk = ~clk;

  xrv1_rf_scb dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .ready_o    (ready),
    .rs_addr_i  (rs_addr),
    .rs_data_o  (rs_data),
    .rs_busy_o  (rs_busy),
    .rd_w_en_i  (rd_w_en),
    .rd_addr_i  (rd_addr),
    .rd_data_i  (rd_data),
    .rsv_en_i   (rsv_en),
    .rsv_addr_i (rsv_addr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return (m_sweep >= 32);
  endfunction

  function automatic logic [31:0] m_rdata(input logic [4:0] a);
    logic [31:0] v;
    if (!m_ready() || a == 5'd0) return 32'h0;
    v = m_mem[a];
`ifdef XRV1_RF_BYPASS_EN
    for (int j = 0; j < 2; j++)
      if (rd_w_en[j] && rd_addr[j*5 +: 5] == a) v = rd_data[j*32 +: 32];
`endif
    return v;
  endfunction

  function automatic logic m_rbusy(input logic [4:0] a);
    if (!m_ready() || a == 5'd0) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic m_reset();
    m_sweep = 0;
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
  endtask

  task automatic m_update();
    if (!m_ready()) begin
      m_sweep++;
      if (m_ready()) for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (rd_w_en[j] && rd_addr[j*5 +: 5] != 5'd0) begin
          m_mem[rd_addr[j*5 +: 5]] = rd_data[j*32 +: 32];
          m_busy[rd_addr[j*5 +: 5]] = 1'b0;
        end
      end
      if (rsv_en && rsv_addr != 5'd0) m_busy[rsv_addr] = 1'b1;
    end
  endtask

  // One clock: the model consumes the inputs present at the edge
  task automatic cycle();
    @(posedge clk);
    if (rst_n) m_update();
    #1;
  endtask

  task automatic set_wr(input int p, input logic en, input logic [4:0] a, input logic [31:0] d);
    rd_w_en[p] = en;
    rd_addr[p*5 +: 5] = a;
    rd_data[p*32 +: 32] = d;
  endtask

  task automatic clear_in();
    rd_w_en = '0;
    rsv_en = 1'b0;
  endtask

  // Continuous compare of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_ready", {31'b0, ready}, {31'b0, m_ready()});
      for (int k = 0; k < 2; k++) begin
        chk("cmp_rs_data", rs_data[k*32 +: 32], m_rdata(rs_addr[k*5 +: 5]));
        chk("cmp_rs_busy", {31'b0, rs_busy[k]}, {31'b0, m_rbusy(rs_addr[k*5 +: 5])});
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
    #2 rst_n = 1'b0;
    m_reset();
    chk_en = 1'b1;
    #1;
    chk("reset_ready", {31'b0, ready}, 32'd0);
    chk("reset_busy", {30'b0, rs_busy}, 32'd0);
    repeat (2) cycle();
    rst_n = 1'b1;

    // Sweep: ready after exactly 32 edges
    repeat (31) cycle();
    chk("sweep_ready_31", {31'b0, ready}, 32'd0);
    cycle();
    chk("sweep_ready_32", {31'b0, ready}, 32'd1);
    for (int a = 0; a < 32; a++) begin
      rs_addr[4:0] = 5'(a);
      rs_addr[9:5] = 5'(31 - a);
      #1;
      chk("sweep_zero_p0", rs_data[31:0], 32'h0);
      chk("sweep_zero_p1", rs_data[63:32], 32'h0);
      cycle();
    end

    // Same-address dual write: higher port wins
    set_wr(0, 1'b1, 5'd5, 32'hDEADBEEF);
    set_wr(1, 1'b1, 5'd5, 32'h12345678);
    cycle();
    clear_in();
    rs_addr = {5'd5, 5'd5};
    #1;
    chk("dual_write_p0", rs_data[31:0], 32'h12345678);
    chk("dual_write_p1", rs_data[63:32], 32'h12345678);

    // Address 0 is hardwired
    set_wr(0, 1'b1, 5'd0, 32'hFFFFFFFF);
    rsv_en = 1'b1; rsv_addr = 5'd0;
    cycle();
    clear_in();
    rs_addr = {5'd5, 5'd0};
    #1;
    chk("x0_data", rs_data[31:0], 32'h0);
    chk("x0_busy", {31'b0, rs_busy[0]}, 32'd0);

    // Reserve / write interaction on address 7
    rsv_en = 1'b1; rsv_addr = 5'd7;
    rs_addr = {5'd7, 5'd7};
    #1;
    chk("rsv_not_bypassed", {31'b0, rs_busy[0]}, 32'd0);
    cycle();
    clear_in();
    #1;
    chk("rsv_busy", {31'b0, rs_busy[1]}, 32'd1);
    rsv_en = 1'b1; rsv_addr = 5'd7;
    set_wr(0, 1'b1, 5'd7, 32'h000000A5);
    cycle();
    clear_in();
    #1;
    chk("rsv_wr_busy", {31'b0, rs_busy[0]}, 32'd1);
    chk("rsv_wr_data", rs_data[63:32], 32'h000000A5);
    rsv_en = 1'b1; rsv_addr = 5'd7;
    cycle();
    clear_in();
    chk("rsv_again_busy", {31'b0, rs_busy[0]}, 32'd1);
    set_wr(1, 1'b1, 5'd7, 32'h00000033);
    cycle();
    clear_in();
    #1;
    chk("wr_clears_busy", {31'b0, rs_busy[0]}, 32'd0);
    chk("wr_alone_data", rs_data[31:0], 32'h00000033);

    // Read during write of the same address
    set_wr(0, 1'b1, 5'd9, 32'h00000011);
    cycle();
    clear_in();
    set_wr(1, 1'b1, 5'd9, 32'h00000055);
    rs_addr = {5'd3, 5'd9};
    #1;
`ifdef XRV1_RF_BYPASS_EN
    chk("same_cycle_read", rs_data[31:0], 32'h00000055);
`else
    chk("same_cycle_read", rs_data[31:0], 32'h00000011);
`endif
    cycle();
    clear_in();
    #1;
    chk("next_cycle_read", rs_data[31:0], 32'h00000055);

    // Reset in READY with busy bits set, then again mid-sweep
    rsv_en = 1'b1; rsv_addr = 5'd3;
    cycle();
    rsv_addr = 5'd7;
    cycle();
    clear_in();
    rs_addr = {5'd3, 5'd7};
    #1;
    chk("pre_rst_busy", {30'b0, rs_busy}, 32'd3);
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    chk("async_rst_busy", {30'b0, rs_busy}, 32'd0);
    chk("async_rst_ready", {31'b0, ready}, 32'd0);
    cycle();
    rst_n = 1'b1;
    set_wr(0, 1'b1, 5'd4, 32'h00000099);
    rsv_en = 1'b1; rsv_addr = 5'd4;
    rs_addr = {5'd4, 5'd4};
    repeat (10) cycle();
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    chk("midsweep_rst_ready", {31'b0, ready}, 32'd0);
    cycle();
    rst_n = 1'b1;
    repeat (31) cycle();
    chk("resweep_ready_31", {31'b0, ready}, 32'd0);
    clear_in();
    cycle();
    chk("resweep_ready_32", {31'b0, ready}, 32'd1);
    chk("init_write_ignored", rs_data[31:0], 32'h0);
    chk("init_rsv_ignored", {31'b0, rs_busy[1]}, 32'd0);
    rs_addr = {5'd7, 5'd9};
    #1;
    chk("resweep_cleared", rs_data[31:0], 32'h0);
    chk("resweep_busy", {30'b0, rs_busy}, 32'd0);
    cycle();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
